pipe_div_unit: RTL
==================

PIPE_DIV_UNIT -- requirements
Module: pipe_div_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have port clk_in  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  global run enable; low freezes all state and outputs.
REQ-005 SHALL have port start  input  1  request from the EX stage to begin a divide.
REQ-006 SHALL have port is_signed  input  1  1 = DIV, 0 = DIVU; sampled with start.
REQ-007 SHALL have port dividend  input  DATA_W  operand rs; sampled with start.
REQ-008 SHALL have port divisor  input  DATA_W  operand rt; sampled with start.
REQ-009 SHALL have port flush  input  1  pipeline flush; aborts any operation.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress; drives the EX-stage stall.
REQ-011 SHALL have port done  output  1  one-cycle pulse; results valid.
REQ-012 SHALL have port quotient  output  DATA_W  LO value.
REQ-013 SHALL have port remainder  output  DATA_W  HI value.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-015 SHALL, in IDLE with start=1 and enable=1, latch operands and is_signed, load the absolute values when signed, clear the iteration counter, and enter CALC.
REQ-016 SHALL perform one restoring shift-subtract step per enabled cycle in CALC, for exactly DATA_W steps, then enter FIX.
REQ-017 SHALL, in FIX, negate the quotient when the signed operand signs differ and negate the remainder when the signed dividend is negative, then enter DONE.
REQ-018 SHALL, in DONE, assert done for exactly one cycle and return to IDLE.
REQ-019 SHALL raise done exactly DATA_W+2 enabled edges after the edge that accepted start (34 for DATA_W=32).
REQ-020 SHALL hold busy=1 from the edge after acceptance until the edge on which DONE is entered; busy=0 in DONE and IDLE.
REQ-021 SHALL ignore start while not in IDLE.
REQ-022 SHALL hold quotient and remainder stable from done until the next accepted start.
REQ-023 SHALL, for divisor==0, produce quotient=all-ones and remainder=dividend with normal latency.
REQ-024 SHALL, for signed most-negative/-1, produce quotient=most-negative and remainder=0.
REQ-025 SHALL, on flush=1 in any state, go to IDLE next edge with busy=0 and done=0, leaving outputs unchanged; flush has priority over start in the same cycle.
REQ-026 SHALL, when enable=0, hold state, counter, and all outputs; a pending done is extended until enable returns.
REQ-027 SHALL keep the counter width at clog2(DATA_W)+1 bits with no wrap-around before terminal count.

Reset
REQ-028 SHALL, on reset=1 at a clock edge, enter IDLE and clear busy, done, quotient, remainder, and all internal registers to 0.
REQ-029 SHALL give reset priority over flush, enable, and start, including mid-operation.

Structure
REQ-030 SHALL take state encodings and DATA_W default from shared package pcpu_div_pkg.
REQ-031 SHALL instantiate one combinational sub-module, div_step, that performs a single shift-subtract step (partial remainder, quotient bit).
REQ-032 SHALL contain no memories or multi-cycle combinational paths; each CALC step is one div_step instance registered per cycle.

Verification
REQ-033 SHALL cover: DIVU 100/7 -> done at edge 34 after start, quotient=14, remainder=2.
REQ-034 SHALL cover: DIV -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
REQ-035 SHALL cover: DIVU 5/0 -> quotient=0xFFFFFFFF, remainder=5; DIV 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-036 SHALL cover: flush at CALC step 10 -> busy=0 next cycle, no done, prior results unchanged; new start 20/3 -> quotient=6, remainder=2.
REQ-037 SHALL cover: enable low for 5 cycles mid-CALC -> done delayed by exactly 5 cycles with correct results; start pulsed while busy -> ignored.
REQ-038 SHALL cover: reset at CALC step 15 -> IDLE, busy=0, quotient=0, remainder=0 next cycle.

Source files
------------

// File: rtl/pcpu_div_pkg.sv
// Shared definitions for the pipelined CPU divide unit: default width and FSM encoding.
package pcpu_div_pkg;

    localparam int unsigned DIV_DATA_W = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shifts the next dividend bit into the partial
// remainder and subtracts the divisor when it fits.
module div_step
    import pcpu_div_pkg::*;
#(
    parameter int unsigned DATA_W = DIV_DATA_W
) (
    input  logic [DATA_W-1:0] rem_in,
    input  logic              next_bit,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_out,
    output logic              q_bit
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    // rem_in < divisor holds for a non-zero divisor, so the top bit of diff is the borrow
    always_comb begin
        shifted = {rem_in, next_bit};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[DATA_W];
        rem_out = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    end

endmodule

// File: rtl/pipe_div_unit.sv
// Multi-cycle DIV/DIVU unit for the EX stage: magnitude division over DATA_W restoring
// steps, then a sign fix-up, then a one-cycle done pulse.
module pipe_div_unit
    import pcpu_div_pkg::*;
#(
    parameter int unsigned DATA_W = DIV_DATA_W
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              enable,
    input  logic              start,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam int unsigned CntW = $clog2(DATA_W) + 1;

    div_state_e        state_q;
    logic [CntW-1:0]   cnt_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] divisor_q;
    logic [DATA_W-1:0] dvd_orig_q;
    logic              is_signed_q;
    logic              dsr_sign_q;
    logic              busy_q;
    logic              done_q;
    logic [DATA_W-1:0] quotient_q;
    logic [DATA_W-1:0] remainder_q;

    logic [DATA_W-1:0] dvd_abs;
    logic [DATA_W-1:0] dsr_abs;
    logic [DATA_W-1:0] step_rem;
    logic              step_qbit;
    logic              neg_quo;
    logic              neg_rem;
    logic [DATA_W-1:0] quo_fix;
    logic [DATA_W-1:0] rem_fix;

    always_comb begin
        dvd_abs = (is_signed && dividend[DATA_W-1]) ? -dividend : dividend;
        dsr_abs = (is_signed && divisor[DATA_W-1]) ? -divisor : divisor;
    end

    // quo_q shifts dividend bits out of the top while quotient bits enter at the bottom
    div_step #(
        .DATA_W (DATA_W)
    ) u_div_step (
        .rem_in   (rem_q),
        .next_bit (quo_q[DATA_W-1]),
        .divisor  (divisor_q),
        .rem_out  (step_rem),
        .q_bit    (step_qbit)
    );

    always_comb begin
        neg_quo = is_signed_q && (dvd_orig_q[DATA_W-1] ^ dsr_sign_q);
        neg_rem = is_signed_q && dvd_orig_q[DATA_W-1];
        quo_fix = neg_quo ? -quo_q : quo_q;
        rem_fix = neg_rem ? -rem_q : rem_q;
        // Divide by zero: all-ones quotient and the untouched dividend, regardless of sign
        if (divisor_q == '0) begin
            quo_fix = '1;
            rem_fix = dvd_orig_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            divisor_q   <= '0;
            dvd_orig_q  <= '0;
            is_signed_q <= 1'b0;
            dsr_sign_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else if (flush) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (enable) begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StCalc;
                        busy_q      <= 1'b1;
                        cnt_q       <= '0;
                        rem_q       <= '0;
                        quo_q       <= dvd_abs;
                        divisor_q   <= dsr_abs;
                        dvd_orig_q  <= dividend;
                        is_signed_q <= is_signed;
                        dsr_sign_q  <= divisor[DATA_W-1];
                    end
                end
                StCalc: begin
                    // Terminal-count cycle after the last step sets the DATA_W+2 latency
                    if (cnt_q == CntW'(DATA_W)) begin
                        state_q <= StFix;
                    end else begin
                        rem_q <= step_rem;
                        quo_q <= {quo_q[DATA_W-2:0], step_qbit};
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StFix: begin
                    quotient_q  <= quo_fix;
                    remainder_q <= rem_fix;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule
